// File: rtl/tan_islem_zamanlayici_if.sv
// ============================================================================
// Module   : tan_islem_zamanlayici_if
// Purpose  : Handshake bundle between two requesters, the scheduler and the
//            shared single-operand function unit.
// Revision : 1.0 - initial release
// ============================================================================
`default_nettype none

interface tan_islem_zamanlayici_if #(
    parameter int GIRIS_W = 32,
    parameter int SONUC_W = 64
);
    logic               istek0;
    logic [GIRIS_W-1:0] sayi0;
    logic               istek1;
    logic [GIRIS_W-1:0] sayi1;
    logic               kabul0;
    logic               kabul1;
    logic               birim_basla;
    logic [GIRIS_W-1:0] birim_sayi;
    logic               birim_hazir;
    logic [SONUC_W-1:0] birim_sonuc;
    logic               birim_gecerli;
    logic [SONUC_W-1:0] sonuc;
    logic               sonuc_hedef;
    logic               sonuc_hazir;
    logic               hata;
    logic               mesgul;

    // Environment side: requesters plus the function unit.
    modport master (
        output istek0, sayi0, istek1, sayi1,
        output birim_hazir, birim_sonuc, birim_gecerli,
        input  kabul0, kabul1, birim_basla, birim_sayi,
        input  sonuc, sonuc_hedef, sonuc_hazir, hata, mesgul
    );

    // Scheduler side.
    modport slave (
        input  istek0, sayi0, istek1, sayi1,
        input  birim_hazir, birim_sonuc, birim_gecerli,
        output kabul0, kabul1, birim_basla, birim_sayi,
        output sonuc, sonuc_hedef, sonuc_hazir, hata, mesgul
    );
endinterface

`default_nettype wire

// File: rtl/tan_islem_zamanlayici.sv
// ============================================================================
// Module   : tan_islem_zamanlayici
// Purpose  : Round-robin scheduler sharing one start/done function unit
//            between two requesters, with completion timeout.
// Revision : 1.0 - initial release
// ============================================================================
`default_nettype none

module tan_islem_zamanlayici #(
    parameter int GIRIS_W     = 32,
    parameter int SONUC_W     = 64,
    parameter int ZAMAN_ASIMI = 64
) (
    input  wire logic              clk,
    input  wire logic              rst,
    tan_islem_zamanlayici_if.slave bus
);
    typedef enum logic [1:0] {
        BOS    = 2'd0,
        BEKLE  = 2'd1,
        TESLIM = 2'd2
    } durum_t;

    localparam logic [7:0] C_SON_SAYAC = 8'(ZAMAN_ASIMI - 1);

    durum_t             durum_q,       durum_d;
    logic               kabul0_q,      kabul0_d;
    logic               kabul1_q,      kabul1_d;
    logic               basla_q,       basla_d;
    logic               sonuc_hazir_q, sonuc_hazir_d;
    logic               hata_q,        hata_d;
    logic               mesgul_q,      mesgul_d;
    logic               sonuc_hedef_q, sonuc_hedef_d;
    logic               son_sahip_q,   son_sahip_d;
    logic [GIRIS_W-1:0] birim_sayi_q,  birim_sayi_d;
    logic [SONUC_W-1:0] sonuc_q,       sonuc_d;
    logic [7:0]         sayac_q,       sayac_d;
    logic               kazanan;

    // With both requesters active the one that did not win last time goes.
    assign kazanan = (bus.istek0 && bus.istek1) ? ~son_sahip_q : bus.istek1;

    always_comb begin
        durum_d       = durum_q;
        kabul0_d      = 1'b0;
        kabul1_d      = 1'b0;
        basla_d       = 1'b0;
        sonuc_hazir_d = 1'b0;
        hata_d        = hata_q;
        sonuc_hedef_d = sonuc_hedef_q;
        son_sahip_d   = son_sahip_q;
        birim_sayi_d  = birim_sayi_q;
        sonuc_d       = sonuc_q;
        sayac_d       = sayac_q;

        case (durum_q)
            BOS: begin
                if (bus.istek0 || bus.istek1) begin
                    durum_d      = BEKLE;
                    birim_sayi_d = kazanan ? bus.sayi1 : bus.sayi0;
                    kabul0_d     = ~kazanan;
                    kabul1_d     = kazanan;
                    basla_d      = 1'b1;
                    sayac_d      = 8'd0;
                    son_sahip_d  = kazanan;
                end
            end
            BEKLE: begin
                // A done pulse coincident with the start strobe belongs to nobody.
                if (!basla_q) begin
                    if (bus.birim_hazir) begin
                        durum_d       = TESLIM;
                        sonuc_d       = bus.birim_sonuc;
                        hata_d        = ~bus.birim_gecerli;
                        sonuc_hazir_d = 1'b1;
                        sonuc_hedef_d = son_sahip_q;
                    end else if (sayac_q == C_SON_SAYAC) begin
                        durum_d       = TESLIM;
                        sonuc_d       = '0;
                        hata_d        = 1'b1;
                        sonuc_hazir_d = 1'b1;
                        sonuc_hedef_d = son_sahip_q;
                    end else begin
                        sayac_d = sayac_q + 8'd1;
                    end
                end
            end
            TESLIM: begin
                durum_d = BOS;
            end
            default: begin
                durum_d = BOS;
            end
        endcase

        mesgul_d = (durum_d != BOS);
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            durum_q       <= BOS;
            kabul0_q      <= 1'b0;
            kabul1_q      <= 1'b0;
            basla_q       <= 1'b0;
            sonuc_hazir_q <= 1'b0;
            hata_q        <= 1'b0;
            mesgul_q      <= 1'b0;
            sonuc_hedef_q <= 1'b0;
            son_sahip_q   <= 1'b1;
            birim_sayi_q  <= '0;
            sonuc_q       <= '0;
            sayac_q       <= 8'd0;
        end else begin
            durum_q       <= durum_d;
            kabul0_q      <= kabul0_d;
            kabul1_q      <= kabul1_d;
            basla_q       <= basla_d;
            sonuc_hazir_q <= sonuc_hazir_d;
            hata_q        <= hata_d;
            mesgul_q      <= mesgul_d;
            sonuc_hedef_q <= sonuc_hedef_d;
            son_sahip_q   <= son_sahip_d;
            birim_sayi_q  <= birim_sayi_d;
            sonuc_q       <= sonuc_d;
            sayac_q       <= sayac_d;
        end
    end

    assign bus.kabul0      = kabul0_q;
    assign bus.kabul1      = kabul1_q;
    assign bus.birim_basla = basla_q;
    assign bus.birim_sayi  = birim_sayi_q;
    assign bus.sonuc       = sonuc_q;
    assign bus.sonuc_hedef = sonuc_hedef_q;
    assign bus.sonuc_hazir = sonuc_hazir_q;
    assign bus.hata        = hata_q;
    assign bus.mesgul      = mesgul_q;

endmodule

`default_nettype wire

// File: tb/tb_tan_islem_zamanlayici.sv
// ============================================================================
// Module   : tb_tan_islem_zamanlayici
// Purpose  : Self-checking bench: directed scenarios plus randomized traffic
//            against a transaction-level model of the scheduler.
// Revision : 1.0 - initial release
// ============================================================================
`default_nettype none

module tb_tan_islem_zamanlayici;
    localparam int GW = 32;
    localparam int SW = 64;
    localparam int ZA = 8;

    logic clk = 1'b0;
    logic rst = 1'b0;
    int   checks = 0;
    int   errors = 0;

    tan_islem_zamanlayici_if #(.GIRIS_W(GW), .SONUC_W(SW)) bus ();

    tan_islem_zamanlayici #(
        .GIRIS_W    (GW),
        .SONUC_W    (SW),
        .ZAMAN_ASIMI(ZA)
    ) dut (
        .clk(clk),
        .rst(rst),
        .bus(bus)
    );

    always #5 clk = ~clk;

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic idle_inputs();
        bus.istek0 = 1'b0; bus.sayi0 = '0;
        bus.istek1 = 1'b0; bus.sayi1 = '0;
        bus.birim_hazir = 1'b0; bus.birim_sonuc = '0; bus.birim_gecerli = 1'b0;
    endtask

    task automatic do_reset();
        idle_inputs();
        rst = 1'b1;
        #2;
        tick();
        rst = 1'b0;
    endtask

    task automatic test_reset();
        idle_inputs();
        #3 rst = 1'b1;
        #1;
        checks++; if (bus.kabul0 !== 1'b0) begin errors++; $display("FAIL rst_kabul0 got %b want 0", bus.kabul0); end
        checks++; if (bus.kabul1 !== 1'b0) begin errors++; $display("FAIL rst_kabul1 got %b want 0", bus.kabul1); end
        checks++; if (bus.birim_basla !== 1'b0) begin errors++; $display("FAIL rst_basla got %b want 0", bus.birim_basla); end
        checks++; if (bus.sonuc_hazir !== 1'b0) begin errors++; $display("FAIL rst_sonuc_hazir got %b want 0", bus.sonuc_hazir); end
        checks++; if (bus.hata !== 1'b0) begin errors++; $display("FAIL rst_hata got %b want 0", bus.hata); end
        checks++; if (bus.mesgul !== 1'b0) begin errors++; $display("FAIL rst_mesgul got %b want 0", bus.mesgul); end
        checks++; if (bus.sonuc_hedef !== 1'b0) begin errors++; $display("FAIL rst_hedef got %b want 0", bus.sonuc_hedef); end
        checks++; if (bus.sonuc !== 64'd0) begin errors++; $display("FAIL rst_sonuc got %h want 0", bus.sonuc); end
        checks++; if (bus.birim_sayi !== 32'd0) begin errors++; $display("FAIL rst_birim_sayi got %h want 0", bus.birim_sayi); end
        repeat (2) tick();
        rst = 1'b0;
    endtask

    task automatic test_single();
        do_reset();
        bus.istek0 = 1'b1; bus.sayi0 = 32'h0000_0003;
        tick(); // cycle 1
        checks++; if (bus.kabul0 !== 1'b1 || bus.kabul1 !== 1'b0) begin errors++; $display("FAIL single_kabul got %b%b want 10", bus.kabul0, bus.kabul1); end
        checks++; if (bus.birim_basla !== 1'b1 || bus.mesgul !== 1'b1) begin errors++; $display("FAIL single_basla got basla=%b mesgul=%b want 1 1", bus.birim_basla, bus.mesgul); end
        checks++; if (bus.birim_sayi !== 32'd3) begin errors++; $display("FAIL single_birim_sayi got %h want 3", bus.birim_sayi); end
        bus.istek0 = 1'b0;
        tick(); // cycle 2
        bus.birim_hazir = 1'b1; bus.birim_sonuc = 64'h1_2345_6789; bus.birim_gecerli = 1'b1;
        tick(); // cycle 3
        bus.birim_hazir = 1'b0;
        checks++; if (bus.sonuc_hazir !== 1'b1) begin errors++; $display("FAIL single_sonuc_hazir got %b want 1", bus.sonuc_hazir); end
        checks++; if (bus.sonuc !== 64'h1_2345_6789) begin errors++; $display("FAIL single_sonuc got %h want 123456789", bus.sonuc); end
        checks++; if (bus.sonuc_hedef !== 1'b0 || bus.hata !== 1'b0) begin errors++; $display("FAIL single_hedef_hata got %b %b want 0 0", bus.sonuc_hedef, bus.hata); end
        tick(); // cycle 4
        checks++; if (bus.sonuc_hazir !== 1'b0 || bus.mesgul !== 1'b0) begin errors++; $display("FAIL single_bos got hazir=%b mesgul=%b want 0 0", bus.sonuc_hazir, bus.mesgul); end
    endtask

    task automatic test_tie();
        do_reset();
        bus.istek0 = 1'b1; bus.sayi0 = 32'd5;
        bus.istek1 = 1'b1; bus.sayi1 = 32'd7;
        tick(); // cycle 1
        checks++; if (bus.kabul0 !== 1'b1 || bus.kabul1 !== 1'b0) begin errors++; $display("FAIL tie_first_kabul got %b%b want 10", bus.kabul0, bus.kabul1); end
        checks++; if (bus.birim_sayi !== 32'd5) begin errors++; $display("FAIL tie_first_sayi got %h want 5", bus.birim_sayi); end
        bus.istek0 = 1'b0;
        tick(); // cycle 2
        bus.birim_hazir = 1'b1; bus.birim_sonuc = 64'hA; bus.birim_gecerli = 1'b1;
        tick(); // cycle 3
        bus.birim_hazir = 1'b0;
        checks++; if (bus.sonuc_hazir !== 1'b1 || bus.sonuc_hedef !== 1'b0 || bus.sonuc !== 64'hA) begin errors++; $display("FAIL tie_first_result got hazir=%b hedef=%b sonuc=%h want 1 0 a", bus.sonuc_hazir, bus.sonuc_hedef, bus.sonuc); end
        tick(); // cycle 4, BOS with istek1 still held
        tick(); // cycle 5
        checks++; if (bus.kabul1 !== 1'b1 || bus.kabul0 !== 1'b0 || bus.birim_basla !== 1'b1) begin errors++; $display("FAIL tie_second_kabul got %b%b basla=%b want 01 1", bus.kabul0, bus.kabul1, bus.birim_basla); end
        checks++; if (bus.birim_sayi !== 32'd7) begin errors++; $display("FAIL tie_second_sayi got %h want 7", bus.birim_sayi); end
        bus.istek1 = 1'b0;
        tick(); // cycle 6
        bus.birim_hazir = 1'b1; bus.birim_sonuc = 64'hB; bus.birim_gecerli = 1'b1;
        tick(); // cycle 7
        bus.birim_hazir = 1'b0;
        checks++; if (bus.sonuc_hazir !== 1'b1 || bus.sonuc_hedef !== 1'b1 || bus.sonuc !== 64'hB) begin errors++; $display("FAIL tie_second_result got hazir=%b hedef=%b sonuc=%h want 1 1 b", bus.sonuc_hazir, bus.sonuc_hedef, bus.sonuc); end
        tick();
    endtask

    task automatic test_timeout();
        do_reset();
        bus.istek1 = 1'b1; bus.sayi1 = 32'h99;
        tick(); // cycle 1: start strobe
        checks++; if (bus.birim_basla !== 1'b1 || bus.kabul1 !== 1'b1) begin errors++; $display("FAIL to_basla got basla=%b kabul1=%b want 1 1", bus.birim_basla, bus.kabul1); end
        bus.istek1 = 1'b0;
        for (int c = 2; c <= ZA + 1; c++) begin
            tick();
            checks++; if (bus.sonuc_hazir !== 1'b0) begin errors++; $display("FAIL to_early cycle %0d got hazir=%b want 0", c, bus.sonuc_hazir); end
        end
        tick(); // cycle ZA+2
        checks++; if (bus.sonuc_hazir !== 1'b1 || bus.hata !== 1'b1 || bus.sonuc !== 64'd0 || bus.sonuc_hedef !== 1'b1) begin
            errors++; $display("FAIL to_deliver got hazir=%b hata=%b sonuc=%h hedef=%b want 1 1 0 1", bus.sonuc_hazir, bus.hata, bus.sonuc, bus.sonuc_hedef); end
        tick(); tick(); tick();
        bus.birim_hazir = 1'b1; bus.birim_sonuc = 64'hDEAD_BEEF; bus.birim_gecerli = 1'b1;
        tick();
        bus.birim_hazir = 1'b0;
        checks++; if (bus.sonuc_hazir !== 1'b0 || bus.sonuc !== 64'd0 || bus.hata !== 1'b1 || bus.mesgul !== 1'b0) begin
            errors++; $display("FAIL to_late got hazir=%b sonuc=%h hata=%b mesgul=%b want 0 0 1 0", bus.sonuc_hazir, bus.sonuc, bus.hata, bus.mesgul); end
    endtask

    task automatic test_invalid();
        do_reset();
        bus.istek0 = 1'b1; bus.sayi0 = 32'h1234;
        tick(); bus.istek0 = 1'b0;
        tick();
        bus.birim_hazir = 1'b1; bus.birim_sonuc = 64'hFFFF; bus.birim_gecerli = 1'b0;
        tick();
        bus.birim_hazir = 1'b0;
        checks++; if (bus.sonuc_hazir !== 1'b1 || bus.sonuc !== 64'hFFFF || bus.hata !== 1'b1) begin
            errors++; $display("FAIL inv_deliver got hazir=%b sonuc=%h hata=%b want 1 ffff 1", bus.sonuc_hazir, bus.sonuc, bus.hata); end
        tick();
        checks++; if (bus.sonuc_hazir !== 1'b0) begin errors++; $display("FAIL inv_pulse got hazir=%b want 0", bus.sonuc_hazir); end
    endtask

    task automatic test_reset_mid();
        do_reset();
        // Leave non-zero result state behind first.
        bus.istek1 = 1'b1; bus.sayi1 = 32'h55;
        tick(); bus.istek1 = 1'b0;
        tick(); bus.birim_hazir = 1'b1; bus.birim_sonuc = 64'hABCD; bus.birim_gecerli = 1'b0;
        tick(); bus.birim_hazir = 1'b0;
        tick();
        bus.istek1 = 1'b1; bus.sayi1 = 32'h66;
        tick(); bus.istek1 = 1'b0;
        tick(); // in BEKLE
        rst = 1'b1;
        #1;
        checks++; if (bus.mesgul !== 1'b0 || bus.sonuc_hazir !== 1'b0 || bus.hata !== 1'b0 || bus.sonuc_hedef !== 1'b0) begin
            errors++; $display("FAIL mid_flags got mesgul=%b hazir=%b hata=%b hedef=%b want 0 0 0 0", bus.mesgul, bus.sonuc_hazir, bus.hata, bus.sonuc_hedef); end
        checks++; if (bus.sonuc !== 64'd0 || bus.birim_sayi !== 32'd0) begin errors++; $display("FAIL mid_data got sonuc=%h sayi=%h want 0 0", bus.sonuc, bus.birim_sayi); end
        tick();
        rst = 1'b0;
        tick();
        bus.birim_hazir = 1'b1; bus.birim_sonuc = 64'h7777; bus.birim_gecerli = 1'b1;
        tick();
        bus.birim_hazir = 1'b0;
        checks++; if (bus.sonuc_hazir !== 1'b0 || bus.mesgul !== 1'b0) begin errors++; $display("FAIL mid_stray got hazir=%b mesgul=%b want 0 0", bus.sonuc_hazir, bus.mesgul); end
        tick();
        checks++; if (bus.sonuc_hazir !== 1'b0 || bus.sonuc !== 64'd0) begin errors++; $display("FAIL mid_stray2 got hazir=%b sonuc=%h want 0 0", bus.sonuc_hazir, bus.sonuc); end
        bus.istek0 = 1'b1; bus.sayi0 = 32'h11;
        bus.istek1 = 1'b1; bus.sayi1 = 32'h22;
        tick();
        checks++; if (bus.kabul0 !== 1'b1 || bus.kabul1 !== 1'b0 || bus.birim_sayi !== 32'h11) begin
            errors++; $display("FAIL mid_tie got kabul=%b%b sayi=%h want 10 11", bus.kabul0, bus.kabul1, bus.birim_sayi); end
        idle_inputs();
    endtask

    task automatic test_ignored();
        do_reset();
        bus.birim_hazir = 1'b1; bus.birim_sonuc = 64'h5555; bus.birim_gecerli = 1'b1;
        tick();
        bus.birim_hazir = 1'b0;
        checks++; if (bus.mesgul !== 1'b0 || bus.sonuc_hazir !== 1'b0 || bus.sonuc !== 64'd0) begin
            errors++; $display("FAIL ign_idle got mesgul=%b hazir=%b sonuc=%h want 0 0 0", bus.mesgul, bus.sonuc_hazir, bus.sonuc); end
        bus.istek0 = 1'b1; bus.sayi0 = 32'h42;
        tick(); // cycle 1, start strobe
        bus.istek0 = 1'b0;
        bus.birim_hazir = 1'b1; bus.birim_sonuc = 64'h1111; bus.birim_gecerli = 1'b0;
        tick(); // cycle 2
        bus.birim_hazir = 1'b0;
        checks++; if (bus.sonuc_hazir !== 1'b0 || bus.mesgul !== 1'b1) begin errors++; $display("FAIL ign_basla got hazir=%b mesgul=%b want 0 1", bus.sonuc_hazir, bus.mesgul); end
        tick(); // cycle 3
        checks++; if (bus.sonuc_hazir !== 1'b0) begin errors++; $display("FAIL ign_wait got hazir=%b want 0", bus.sonuc_hazir); end
        bus.birim_hazir = 1'b1; bus.birim_sonuc = 64'h2222; bus.birim_gecerli = 1'b1;
        tick(); // cycle 4
        bus.birim_hazir = 1'b0;
        checks++; if (bus.sonuc_hazir !== 1'b1 || bus.sonuc !== 64'h2222 || bus.hata !== 1'b0) begin
            errors++; $display("FAIL ign_deliver got hazir=%b sonuc=%h hata=%b want 1 2222 0", bus.sonuc_hazir, bus.sonuc, bus.hata); end
        tick();
    endtask

    // Transaction-level model: pending requests, round-robin pointer, and the
    // unit's response latency decide grant order and what gets delivered when.
    task automatic test_random();
        logic        pend [2];
        logic [31:0] opnd [2];
        logic        last, win, gec, noise;
        logic [63:0] res, exp_sonuc;
        logic        exp_hata;
        int          lat, dlv;
        do_reset();
        last = 1'b1;
        pend[0] = 1'b0; pend[1] = 1'b0;
        opnd[0] = '0;   opnd[1] = '0;
        for (int n = 0; n < 60; n++) begin
            for (int r = 0; r < 2; r++)
                if (!pend[r] && $urandom_range(0, 1) == 1) begin pend[r] = 1'b1; opnd[r] = $urandom; end
            if (!pend[0] && !pend[1]) begin pend[0] = 1'b1; opnd[0] = $urandom; end
            bus.istek0 = pend[0]; bus.sayi0 = opnd[0];
            bus.istek1 = pend[1]; bus.sayi1 = opnd[1];
            win   = (pend[0] && pend[1]) ? ~last : pend[1];
            lat   = ($urandom_range(0, 5) == 0) ? ZA + int'($urandom_range(1, 2)) : int'($urandom_range(1, ZA));
            res   = {$urandom, $urandom};
            gec   = ($urandom_range(0, 3) != 0);
            noise = ($urandom_range(0, 1) == 1);
            dlv       = (lat <= ZA) ? lat + 2 : ZA + 2;
            exp_sonuc = (lat <= ZA) ? res : 64'd0;
            exp_hata  = (lat <= ZA) ? ~gec : 1'b1;
            tick(); // cycle 1
            checks++; if (bus.kabul0 !== ~win || bus.kabul1 !== win || bus.birim_basla !== 1'b1) begin
                errors++; $display("FAIL rnd_grant op %0d got kabul=%b%b basla=%b want win=%0d", n, bus.kabul0, bus.kabul1, bus.birim_basla, win); end
            checks++; if (bus.birim_sayi !== opnd[win]) begin errors++; $display("FAIL rnd_sayi op %0d got %h want %h", n, bus.birim_sayi, opnd[win]); end
            last = win;
            pend[win] = 1'b0;
            if (win) bus.istek1 = 1'b0; else bus.istek0 = 1'b0;
            for (int c = 1; c <= dlv; c++) begin
                bus.birim_hazir   = (c == lat + 1) || (c == 1 && noise);
                bus.birim_sonuc   = (c == lat + 1) ? res : {$urandom, $urandom};
                bus.birim_gecerli = (c == lat + 1) ? gec : 1'($urandom_range(0, 1));
                tick();
                checks++; if (bus.sonuc_hazir !== (c + 1 == dlv)) begin
                    errors++; $display("FAIL rnd_timing op %0d cycle %0d got hazir=%b want %b", n, c + 1, bus.sonuc_hazir, (c + 1 == dlv)); end
                if (c + 1 == dlv) begin
                    checks++; if (bus.sonuc !== exp_sonuc || bus.hata !== exp_hata || bus.sonuc_hedef !== win || bus.mesgul !== 1'b1) begin
                        errors++; $display("FAIL rnd_result op %0d got sonuc=%h hata=%b hedef=%b mesgul=%b want %h %b %b 1",
                                           n, bus.sonuc, bus.hata, bus.sonuc_hedef, bus.mesgul, exp_sonuc, exp_hata, win); end
                end
            end
            checks++; if (bus.mesgul !== 1'b0) begin errors++; $display("FAIL rnd_bos op %0d got mesgul=%b want 0", n, bus.mesgul); end
            bus.birim_hazir = (dlv + 1 == lat + 1);
            bus.birim_sonuc = {$urandom, $urandom};
        end
        idle_inputs();
        tick();
    endtask

    initial begin
        idle_inputs();
        test_reset();
        test_single();
        test_tie();
        test_timeout();
        test_invalid();
        test_reset_mid();
        test_ignored();
        test_random();
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule

`default_nettype wire
